// File: rtl/sfp2fix_group.sv
// sfp2fix_group: block-floating-point aligner ahead of the fixed-point adder tree.
// Collects GROUP sfp words, finds the shared maximum exponent over the non-zero
// words, then emits each word as a two's-complement value aligned to it.
// The LSB of out_data weighs 2^(out_max_exp - sigWidth - low_expand).

module sfp2fix_group #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int low_expand  = 2,
  parameter int GROUP       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [formatWidth-1:0]           in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [sigWidth+4+low_expand-1:0] out_data,
  output logic [expWidth-1:0]              out_max_exp,
  output logic                             out_last
);

  localparam int OW = sigWidth + 4 + low_expand;  // aligned output width
  localparam int MW = sigWidth + 1 + low_expand;  // magnitude width incl. hidden one
  localparam int CW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [CW-1:0]       LAST_IDX = CW'(GROUP - 1);
  localparam logic [expWidth-1:0] SH_MAX   = expWidth'(sigWidth + low_expand);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [expWidth-1:0]     run_max_q, run_max_d;
  logic [formatWidth-1:0]  buf_q [GROUP];
  logic [formatWidth-1:0]  buf_d [GROUP];
  logic [expWidth-1:0]     in_exp;

  // Align one sfp word to the group exponent; magnitude is truncated before negation.
  function automatic logic [OW-1:0] conv(input logic [formatWidth-1:0] w,
                                         input logic [expWidth-1:0]    mx);
    logic [expWidth-1:0] e;
    logic [sigWidth-1:0] m;
    logic                s;
    logic [expWidth-1:0] d;
    logic [MW-1:0]       base;
    logic [MW-1:0]       mag;
    logic [OW-1:0]       ext;
    e    = w[formatWidth-2:sigWidth];
    m    = w[sigWidth-1:0];
    s    = w[formatWidth-1];
    d    = mx - e;
    base = {1'b1, m, {low_expand{1'b0}}};
    if (e == {expWidth{1'b0}}) begin
      mag = {MW{1'b0}};
    end else if (d > SH_MAX) begin
      mag = {MW{1'b0}};
    end else begin
      mag = base >> d;
    end
    ext = {{(OW - MW){1'b0}}, mag};
    if (s) begin
      conv = {OW{1'b0}} - ext;
    end else begin
      conv = ext;
    end
  endfunction

  assign in_exp = in_data[formatWidth-2:sigWidth];

  // State, counters, running maximum and word buffer; rst discards any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= {CW{1'b0}};
      idx_q     <= {CW{1'b0}};
      run_max_q <= {expWidth{1'b0}};
      for (int i = 0; i < GROUP; i++) begin
        buf_q[i] <= {formatWidth{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      run_max_q <= run_max_d;
      for (int i = 0; i < GROUP; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Next state: fill the buffer one word per accept, then drain one word per handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_max_d = run_max_q;
    buf_d     = buf_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          buf_d[cnt_q] = in_data;
          // zero words (exp==0) never raise the shared exponent
          if ((in_exp != {expWidth{1'b0}}) && (in_exp > run_max_q)) begin
            run_max_d = in_exp;
          end else begin
            run_max_d = run_max_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = EMIT;
            cnt_d   = {CW{1'b0}};
            idx_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d   = FILL;
            cnt_d     = {CW{1'b0}};
            idx_d     = {CW{1'b0}};
            run_max_d = {expWidth{1'b0}};
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d   = FILL;
        cnt_d     = {CW{1'b0}};
        idx_d     = {CW{1'b0}};
        run_max_d = {expWidth{1'b0}};
      end
    endcase
  end

  // Outputs decode from state flops and are forced to zero while rst is high.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = {OW{1'b0}};
    out_max_exp = {expWidth{1'b0}};
    out_last    = 1'b0;
    if (!rst) begin
      case (state_q)
        FILL: begin
          in_ready = 1'b1;
        end
        EMIT: begin
          out_valid   = 1'b1;
          out_data    = conv(buf_q[idx_q], run_max_q);
          out_max_exp = run_max_q;
          out_last    = (idx_q == LAST_IDX);
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end else begin
      in_ready = 1'b0;
    end
  end

endmodule
